// File: rtl/mem_reinit_pkg.sv
// Shared types for the memory reinit readback path: streamer FSM states and
// the default checksum width.
package mem_reinit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int CSUM_W_DEF = 16;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO with registered storage; dout always presents the head entry.
// Flush empties the FIFO without clearing the storage.
module stream_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         push_ok, pop_ok;

   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_readback_streamer.sv
// Sweeps a synchronous RAM from address 0 to DEPTH_MEM-1 and streams each word
// with its address, a last flag and a running checksum of accepted words.
module mem_readback_streamer
   import mem_reinit_pkg::*;
#(
   parameter int WID_MEM   = 8,
   parameter int DEPTH_MEM = 8192,
   parameter int ADDR_W    = $clog2(DEPTH_MEM),
   parameter int CSUM_W    = CSUM_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  mem_raddr,
   output logic               mem_rd_en,
   input  logic [WID_MEM-1:0] mem_dout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WID_MEM-1:0] out_data,
   output logic [ADDR_W-1:0]  out_addr,
   output logic               out_last,
   output logic [CSUM_W-1:0]  checksum,
   output state_t             dbg_state
);

   localparam int                EW        = WID_MEM + ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

   // Stream handshake: a word transfers on a rising edge where out_valid and
   // out_ready are both high; out_* hold steady while out_valid waits for ready.
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   issue_addr_q, issue_addr_d;
   logic                inflight_q, inflight_d;
   logic [ADDR_W-1:0]   inflight_addr_q, inflight_addr_d;
   logic [CSUM_W-1:0]   csum_q, csum_d;
   logic                done_q, done_d;

   logic                pop, push, issue, drain_done;
   logic [2:0]          occ_after;
   logic [EW-1:0]       fifo_din, fifo_dout;
   logic                fifo_full, fifo_empty;
   logic [1:0]          fifo_count;

   assign pop       = out_valid & out_ready & ~abort;
   assign push      = inflight_q & ~abort;
   // Counting the in-flight read as occupied caps outstanding reads at two.
   assign occ_after = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = (state_q == RUN) && !abort && (occ_after < 3'd2);
   assign drain_done = !inflight_q && !fifo_full && (fifo_empty || pop);
   assign fifo_din  = {mem_dout, inflight_addr_q, (inflight_addr_q == LAST_ADDR)};

   stream_fifo2 #(.W(EW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (abort),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d         = state_q;
      issue_addr_d    = issue_addr_q;
      inflight_d      = issue;
      inflight_addr_d = issue ? issue_addr_q : inflight_addr_q;
      csum_d          = csum_q;
      done_d          = 1'b0;
      if (pop) begin
         csum_d = csum_q + CSUM_W'(out_data);
      end
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d      = RUN;
               issue_addr_d = '0;
               csum_d       = '0;
            end
         end
         RUN: begin
            if (issue) begin
               if (issue_addr_q == LAST_ADDR) begin
                  state_d = DRAIN;
               end else begin
                  issue_addr_d = issue_addr_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_done) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d    = IDLE;
         inflight_d = 1'b0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         issue_addr_q    <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         csum_q          <= '0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         issue_addr_q    <= issue_addr_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         csum_q          <= csum_d;
         done_q          <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign mem_raddr = issue_addr_q;
   assign mem_rd_en = issue;
   assign out_valid = ~fifo_empty;
   assign {out_data, out_addr, out_last} = fifo_dout;
   assign checksum  = csum_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Bench for mem_readback_streamer: a 16-word instance for sweep, backpressure,
// abort and reset cases, and a 300-word instance for checksum wrap.
module tb_mem_readback_streamer;
   import mem_reinit_pkg::*;

   localparam int DA = 16;
   localparam int AWA = 4;
   localparam int DB = 300;
   localparam int AWB = 9;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // instance A
   logic           start_a = 1'b0, abort_a = 1'b0, rdy_a = 1'b0;
   logic           busy_a, done_a, mem_rd_en_a, out_valid_a, out_last_a;
   logic [AWA-1:0] mem_raddr_a, out_addr_a;
   logic [7:0]     mem_dout_a = 8'h00, out_data_a;
   logic [15:0]    checksum_a;
   state_t         dbg_state_a;
   logic [7:0]     ram_a [DA];

   // instance B
   logic           start_b = 1'b0, abort_b = 1'b0, rdy_b = 1'b0;
   logic           busy_b, done_b, mem_rd_en_b, out_valid_b, out_last_b;
   logic [AWB-1:0] mem_raddr_b, out_addr_b;
   logic [7:0]     mem_dout_b = 8'h00, out_data_b;
   logic [15:0]    checksum_b;
   state_t         dbg_state_b;

   mem_readback_streamer #(.WID_MEM(8), .DEPTH_MEM(DA), .CSUM_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
      .busy(busy_a), .done(done_a), .mem_raddr(mem_raddr_a), .mem_rd_en(mem_rd_en_a),
      .mem_dout(mem_dout_a), .out_valid(out_valid_a), .out_ready(rdy_a),
      .out_data(out_data_a), .out_addr(out_addr_a), .out_last(out_last_a),
      .checksum(checksum_a), .dbg_state(dbg_state_a)
   );

   mem_readback_streamer #(.WID_MEM(8), .DEPTH_MEM(DB), .CSUM_W(16)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
      .busy(busy_b), .done(done_b), .mem_raddr(mem_raddr_b), .mem_rd_en(mem_rd_en_b),
      .mem_dout(mem_dout_b), .out_valid(out_valid_b), .out_ready(rdy_b),
      .out_data(out_data_b), .out_addr(out_addr_b), .out_last(out_last_b),
      .checksum(checksum_b), .dbg_state(dbg_state_b)
   );

   // synchronous RAM models: data valid one cycle after the sampled read
   always @(posedge clk) begin
      if (mem_rd_en_a) mem_dout_a <= ram_a[mem_raddr_a];
      if (mem_rd_en_b) mem_dout_b <= 8'hFF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // scoreboard for instance A: {data, addr, last}
   logic [12:0] exp_q [$];
   int          pops_a = 0;
   logic        hold_v = 1'b0;
   logic [12:0] hold_w = '0;

   always @(negedge clk) begin
      logic [12:0] w;
      if (reset && out_valid_a) begin
         if (hold_v) check("stall_stable", {19'd0, out_data_a, out_addr_a, out_last_a}, {19'd0, hold_w});
         if (rdy_a && !abort_a) begin
            pops_a++;
            hold_v = 1'b0;
            if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
            else begin
               w = exp_q.pop_front();
               check("word", {19'd0, out_data_a, out_addr_a, out_last_a}, {19'd0, w});
            end
         end else if (!abort_a) begin
            hold_v = 1'b1;
            hold_w = {out_data_a, out_addr_a, out_last_a};
         end else hold_v = 1'b0;
      end else if (hold_v) begin
         check("stall_valid", {31'd0, out_valid_a}, 32'd1);
         hold_v = 1'b0;
      end
   end

   // instance B monitor
   int       pops_b = 0, bad_b = 0, lasts_b = 0;
   logic [AWB-1:0] last_addr_b = '0;
   always @(negedge clk) begin
      if (reset && out_valid_b && rdy_b) begin
         pops_b++;
         if (out_data_b != 8'hFF) bad_b++;
         if (out_last_b) begin
            lasts_b++;
            last_addr_b = out_addr_b;
         end
      end
   end

   task automatic push_expected(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({8'(i + 1), 4'(i), (i == DA - 1)});
   endtask

   task automatic run_sweep(input logic [3:0] pat, input int abort_at,
                            input logic [15:0] exp_csum, input logic exp_done);
      int   base = pops_a;
      int   done_cyc = -1;
      logic done_seen = 1'b0;
      logic finished = 1'b0;
      push_expected(abort_at < 0 ? DA : abort_at);
      start_a = 1'b1;
      rdy_a   = pat[3];
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         rdy_a = pat[3 - (k % 4)];
         if (abort_at >= 0 && (pops_a - base) == abort_at) begin
            rdy_a   = 1'b0;
            abort_a = 1'b1;
            @(posedge clk); #1;
            abort_a = 1'b0;
            check("abort_busy", {31'd0, busy_a}, 32'd0);
            check("abort_valid", {31'd0, out_valid_a}, 32'd0);
            repeat (4) begin
               @(posedge clk); #1;
               if (done_a) done_seen = 1'b1;
            end
            finished = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (done_a) begin
            done_seen = 1'b1;
            done_cyc  = k;
            finished  = 1'b1;
            @(posedge clk); #1;
            check("done_pulse_width", {31'd0, done_a}, 32'd0);
            break;
         end
      end
      check("sweep_finished", {31'd0, finished}, 32'd1);
      check("done_seen", {31'd0, done_seen}, {31'd0, exp_done});
      if (pat == 4'b1111 && abort_at < 0) check("done_latency", done_cyc, 32'd18);
      check("checksum", {16'd0, checksum_a}, {16'd0, exp_csum});
      check("queue_empty", exp_q.size(), 32'd0);
      check("idle_after", {30'd0, dbg_state_a}, {30'd0, IDLE});
      exp_q.delete();
      rdy_a = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  rdy_pat;
      int          abort_at;
      logic [15:0] exp_csum;
      logic        exp_done;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int   issues;
      int   base;
      logic ok;
      for (int i = 0; i < DA; i++) ram_a[i] = 8'(i + 1);

      tbl[0] = '{4'b1111, -1, 16'd136, 1'b1};
      tbl[1] = '{4'b1001, -1, 16'd136, 1'b1};
      tbl[2] = '{4'b0101, -1, 16'd136, 1'b1};
      tbl[3] = '{4'b1111,  5, 16'd15,  1'b0};
      tbl[4] = '{4'b1001, 10, 16'd55,  1'b0};
      tbl[5] = '{4'($urandom_range(1, 15)), -1, 16'd136, 1'b1};

      // reset values while reset is held
      #2;
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_done", {31'd0, done_a}, 32'd0);
      check("rst_raddr", {28'd0, mem_raddr_a}, 32'd0);
      check("rst_rd_en", {31'd0, mem_rd_en_a}, 32'd0);
      check("rst_valid", {31'd0, out_valid_a}, 32'd0);
      check("rst_data", {24'd0, out_data_a}, 32'd0);
      check("rst_addr", {28'd0, out_addr_a}, 32'd0);
      check("rst_last", {31'd0, out_last_a}, 32'd0);
      check("rst_csum", {16'd0, checksum_a}, 32'd0);
      check("rst_state", {30'd0, dbg_state_a}, {30'd0, IDLE});
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 6; v++) begin
         run_sweep(tbl[v].rdy_pat, tbl[v].abort_at, tbl[v].exp_csum, tbl[v].exp_done);
         repeat (2) @(posedge clk);
         #1;
      end

      // start and abort together in IDLE: abort wins
      start_a = 1'b1;
      abort_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      abort_a = 1'b0;
      check("start_abort_busy", {31'd0, busy_a}, 32'd0);
      check("start_abort_rd_en", {31'd0, mem_rd_en_a}, 32'd0);

      // stall at first word: at most two reads before the first pop
      push_expected(DA);
      start_a = 1'b1;
      rdy_a   = 1'b0;
      @(posedge clk); #1;
      start_a = 1'b0;
      issues  = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_rd_en_a) issues++;
         @(posedge clk); #1;
      end
      check("stall_issues", issues, 32'd2);
      check("stall_rd_en_low", {31'd0, mem_rd_en_a}, 32'd0);
      check("stall_head_addr", {28'd0, out_addr_a}, 32'd0);
      rdy_a = 1'b1;
      #1;
      check("stall_rd_en_on_pop", {31'd0, mem_rd_en_a}, 32'd1);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (done_a) begin
            ok = 1'b1;
            break;
         end
      end
      check("stall_done", {31'd0, ok}, 32'd1);
      check("stall_csum", {16'd0, checksum_a}, 32'd136);
      check("stall_queue_empty", exp_q.size(), 32'd0);
      rdy_a = 1'b0;
      @(posedge clk); #1;

      // asynchronous reset in the middle of a sweep
      base = pops_a;
      push_expected(DA);
      start_a = 1'b1;
      rdy_a   = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if ((pops_a - base) == 7) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("reset_reached_word7", {31'd0, ok}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy_a}, 32'd0);
      check("arst_raddr", {28'd0, mem_raddr_a}, 32'd0);
      check("arst_rd_en", {31'd0, mem_rd_en_a}, 32'd0);
      check("arst_valid", {31'd0, out_valid_a}, 32'd0);
      check("arst_data", {24'd0, out_data_a}, 32'd0);
      check("arst_addr", {28'd0, out_addr_a}, 32'd0);
      check("arst_last", {31'd0, out_last_a}, 32'd0);
      check("arst_csum", {16'd0, checksum_a}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      base = pops_a;
      repeat (3) @(posedge clk);
      #1;
      check("no_output_after_reset", pops_a - base, 32'd0);
      run_sweep(4'b1111, -1, 16'd136, 1'b1);

      // checksum wrap on the 300-word instance, with a start pulse mid-sweep
      base    = pops_b;
      start_b = 1'b1;
      rdy_b   = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      issues  = -1;
      for (int k = 1; k <= 400; k++) begin
         start_b = (k == 50);
         @(posedge clk); #1;
         if (done_b) begin
            issues = k;
            break;
         end
      end
      start_b = 1'b0;
      check("wrap_done_latency", issues, 32'd302);
      check("wrap_words", pops_b - base, 32'd300);
      check("wrap_data", bad_b, 32'd0);
      check("wrap_last_count", lasts_b, 32'd1);
      check("wrap_last_addr", {23'd0, last_addr_b}, 32'd299);
      check("wrap_csum", {16'd0, checksum_b}, 32'd10964);
      @(posedge clk); #1;
      check("wrap_busy_after", {31'd0, busy_b}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
